// File: rtl/ntru_encrypt.sv
// NTRU-HRSS encryption core: c = r*h + m_lift in Zq[x]/(x^N - 1), one r coefficient per cycle.
// Optional `PHI1_LIFT_EN: m_in is ternary and is lifted as (x-1)*m before accumulation.
module ntru_encrypt #(
    parameter int N     = 701,
    parameter int QBITS = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*N-1:0]       r_in,
    input  logic [QBITS*N-1:0]   h_in,
`ifdef PHI1_LIFT_EN
    input  logic [2*N-1:0]       m_in,
`else
    input  logic [QBITS*N-1:0]   m_in,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [QBITS*N-1:0]   c_out
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   k_reg;
    logic [2*N-1:0]  r_reg;
    logic            done_reg;
    logic            accept;
    logic [1:0]      t;

    // The done-pulse cycle counts as part of the operation, so a new start waits for it.
    assign busy   = (state_reg != IDLE) || done_reg;
    assign done   = done_reg;
    assign accept = (state_reg == IDLE) && start && !done_reg;

    // r_reg shifts down two bits per step, so the current coefficient is always the low pair.
    assign t = r_reg[1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (k_reg == KW'(N - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            r_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == DONE);
            if (accept) begin
                r_reg <= r_in;
                k_reg <= '0;
            end else if (state_reg == MAC) begin
                r_reg <= r_reg >> 2;
                k_reg <= k_reg + KW'(1);
            end
        end
    end

`ifdef PHI1_LIFT_EN
    function automatic logic [QBITS-1:0] tern(input logic [1:0] code);
        case (code)
            2'b01:   return QBITS'(1);
            2'b10:   return '1;
            default: return '0;
        endcase
    endfunction
`endif

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_coef
            localparam int PREV = (gi + N - 1) % N;

            logic [QBITS-1:0] acc_reg;
            logic [QBITS-1:0] h_rot_reg;
            logic [QBITS-1:0] c_reg;
            logic [QBITS-1:0] m_lift;

`ifdef PHI1_LIFT_EN
            assign m_lift = tern(m_in[2*PREV +: 2]) - tern(m_in[2*gi +: 2]);
`else
            assign m_lift = m_in[QBITS*gi +: QBITS];
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg   <= '0;
                    h_rot_reg <= '0;
                    c_reg     <= '0;
                end else begin
                    if (accept) begin
                        acc_reg   <= m_lift;
                        h_rot_reg <= h_in[QBITS*gi +: QBITS];
                    end else if (state_reg == MAC) begin
                        // Rotating h up each step makes h_rot[j] = h[(j-k) mod N] at step k.
                        h_rot_reg <= g_coef[PREV].h_rot_reg;
                        case (t)
                            2'b01:   acc_reg <= acc_reg + h_rot_reg;
                            2'b10:   acc_reg <= acc_reg - h_rot_reg;
                            default: acc_reg <= acc_reg;
                        endcase
                    end
                    if (state_reg == DONE) c_reg <= acc_reg;
                end
            end

            assign c_out[QBITS*gi +: QBITS] = c_reg;
        end
    endgenerate

endmodule
